// File: rtl/sevenseg_scan_if.sv
// Write port and pin bundle for the 8-digit seven-segment scanner.
// master = display register side, slave = scanner.
interface sevenseg_scan_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [7:0]  wr_mask;
    logic [7:0]  wr_dp;
    logic        pending;
    logic        frame_start;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    modport master (
        output wr_en, wr_data, wr_mask, wr_dp,
        input  pending, frame_start, an, seg, dp_n
    );

    modport slave (
        input  wr_en, wr_data, wr_mask, wr_dp,
        output pending, frame_start, an, seg, dp_n
    );
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit common-anode driver with frame-boundary double buffering.
// Optional: SEVENSEG_LEADING_ZERO_BLANK_EN blanks enabled digits above the top non-zero nibble.
module sevenseg_scan #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input logic             clk,
    input logic             rst,
    sevenseg_scan_if.slave  bus
);
    localparam int DIV = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  mask;
        logic [7:0]  dp;
    } disp_t;

    typedef enum logic {BLANK, SHOW} state_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Mask actually loaded into the active buffer; digit 0 always keeps its enable.
    function automatic disp_t effective(input disp_t v);
        disp_t r;
        r = v;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        begin
            logic [2:0] top;
            top = 3'd0;
            for (int k = 0; k < 8; k++)
                if (v.mask[k] && (v.data[4*k +: 4] != 4'h0)) top = 3'(k);
            for (int k = 1; k < 8; k++)
                if (3'(k) > top) r.mask[k] = 1'b0;
        end
`endif
        return r;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q;
    state_t        state_q, state_d;
    disp_t         act_q, pend_q, wr_s;
    logic          pend_vld_q;
    logic          wrap, boundary;

    logic [7:0]    an_d, an_q;
    logic [6:0]    seg_d, seg_q;
    logic          dp_n_d, dp_n_q, fs_q;
    logic [3:0]    nib;

    assign wr_s     = '{data: bus.wr_data, mask: bus.wr_mask, dp: bus.wr_dp};
    assign wrap     = (cnt_q == CNT_LAST);
    assign boundary = wrap && (idx_q == 3'd7);
    assign cnt_d    = wrap ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            if (wrap) idx_q <= idx_q + 3'd1;
        end
    end

    // The state tracks the counter value it will be paired with next cycle.
    always_ff @(posedge clk) begin
        if (rst) state_q <= BLANK;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = SHOW;
        if (cnt_d < CNT_BLANK) state_d = BLANK;
    end

    assign nib = act_q.data[{idx_q, 2'b00} +: 4];

    always_comb begin
        an_d   = 8'hFF;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        if (state_q == SHOW) begin
            if (act_q.mask[idx_q]) an_d = ~(8'h01 << idx_q);
            seg_d  = hex7(nib);
            dp_n_d = ~act_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
            dp_n_q <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            fs_q   <= (cnt_q == '0) && (idx_q == 3'd0);
        end
    end

    // A write landing on the boundary bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (boundary) begin
            if (bus.wr_en)       act_q <= effective(wr_s);
            else if (pend_vld_q) act_q <= effective(pend_q);
            pend_vld_q <= 1'b0;
        end else if (bus.wr_en) begin
            pend_q     <= wr_s;
            pend_vld_q <= 1'b1;
        end
    end

    assign bus.pending     = pend_vld_q;
    assign bus.frame_start = fs_q;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp_n        = dp_n_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a cycle model pushes expected pins, the DUT side pops and compares.
module tb_sevenseg_scan;
    localparam int DIV   = 10;
    localparam int BLANK = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sevenseg_scan_if bus();

    sevenseg_scan #(.CLK_FREQ_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    logic [6:0] lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int          m_cyc = 0;
    logic [31:0] a_data = '0, p_data = '0;
    logic [7:0]  a_mask = '0, p_mask = '0, a_dp = '0, p_dp = '0;
    logic        p_flag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Effective mask as seen after apply; scanned from the top digit down.
    function automatic logic [7:0] eff_mask(input logic [31:0] d, input logic [7:0] m);
        logic [7:0] r;
        r = m;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        begin
            logic stop;
            stop = 1'b0;
            for (int k = 7; k >= 1; k--) begin
                if (!stop && m[k]) begin
                    if (d[4*k +: 4] != 4'h0) stop = 1'b1;
                    else r[k] = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        int c, d;
        c = m_cyc % DIV;
        d = (m_cyc / DIV) % 8;
        e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, pend: 1'b0, fs: 1'b0};
        if (rst) begin
            m_cyc = 0; p_flag = 1'b0;
            a_data = '0; a_mask = '0; a_dp = '0;
            p_data = '0; p_mask = '0; p_dp = '0;
        end else begin
            e.fs = (c == 0) && (d == 0);
            if (c >= BLANK) begin
                if (a_mask[d]) e.an = ~(8'h01 << d);
                e.seg = lut[a_data[4*d +: 4]];
                e.dp  = ~a_dp[d];
            end
            if (c == DIV-1 && d == 7) begin
                if (bus.wr_en) begin
                    a_data = bus.wr_data; a_mask = eff_mask(bus.wr_data, bus.wr_mask); a_dp = bus.wr_dp;
                end else if (p_flag) begin
                    a_data = p_data; a_mask = eff_mask(p_data, p_mask); a_dp = p_dp;
                end
                p_flag = 1'b0;
            end else if (bus.wr_en) begin
                p_data = bus.wr_data; p_mask = bus.wr_mask; p_dp = bus.wr_dp;
                p_flag = 1'b1;
            end
            e.pend = p_flag;
            m_cyc++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_an",   bus.an,          e.an);
        chk("sb_seg",  bus.seg,         e.seg);
        chk("sb_dp",   bus.dp_n,        e.dp);
        chk("sb_pend", bus.pending,     e.pend);
        chk("sb_fs",   bus.frame_start, e.fs);
    endtask

    task automatic wr(input logic [31:0] data, input logic [7:0] mask, input logic [7:0] dp);
        bus.wr_en = 1'b1; bus.wr_data = data; bus.wr_mask = mask; bus.wr_dp = dp;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic goto(input int c, input int d);
        int guard;
        guard = 0;
        while (!((m_cyc % DIV) == c && ((m_cyc / DIV) % 8) == d) && guard < 200) begin
            tick();
            guard++;
        end
    endtask

    // After this the pins reflect slot d, counter c.
    task automatic show_at(input int c, input int d);
        goto(c, d);
        tick();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_mask = '0; bus.wr_dp = '0;
        repeat (3) tick();
        chk("rst_an",   bus.an,      8'hFF);
        chk("rst_seg",  bus.seg,     7'h7F);
        chk("rst_dp",   bus.dp_n,    1'b1);
        chk("rst_pend", bus.pending, 1'b0);
        chk("rst_fs",   bus.frame_start, 1'b0);
        rst = 1'b0;
        tick();
        chk("fs_first", bus.frame_start, 1'b1);
        tick();
        chk("fs_once", bus.frame_start, 1'b0);

        wr(32'h8765_4321, 8'hFF, 8'h01);
        chk("wr_pend", bus.pending, 1'b1);
        goto(0, 0);
        show_at(1, 0);
        chk("blank_an", bus.an, 8'hFF);
        chk("blank_seg", bus.seg, 7'h7F);
        show_at(2, 0);
        chk("s0_an", bus.an, 8'hFE);
        chk("s0_seg", bus.seg, 7'b1001111);
        chk("s0_dp", bus.dp_n, 1'b0);
        show_at(5, 7);
        chk("s7_an", bus.an, 8'h7F);
        chk("s7_seg", bus.seg, 7'b0000000);
        chk("s7_dp", bus.dp_n, 1'b1);

        goto(3, 2);
        wr(32'h1111_1111, 8'hFF, 8'h00);
        goto(5, 4);
        wr(32'h2222_2222, 8'hFF, 8'h00);
        chk("lww_pend", bus.pending, 1'b1);
        show_at(5, 5);
        chk("old_an", bus.an, 8'hDF);
        chk("old_seg", bus.seg, 7'b0100000);
        show_at(8, 7);
        chk("pend_hold", bus.pending, 1'b1);
        show_at(3, 3);
        chk("new_seg", bus.seg, 7'b0010010);
        chk("new_pend", bus.pending, 1'b0);

        goto(9, 7);
        wr(32'hFFFF_FFFF, 8'hFF, 8'h00);
        chk("byp_pend", bus.pending, 1'b0);
        show_at(4, 6);
        chk("byp_an", bus.an, 8'hBF);
        chk("byp_seg", bus.seg, 7'b0111000);

        wr(32'hDEAD_BEEF, 8'h0F, 8'h00);
        goto(0, 0);
        show_at(2, 0);
        chk("m0_seg", bus.seg, 7'b0111000);
        show_at(2, 1);
        chk("m1_seg", bus.seg, 7'b0110000);
        show_at(6, 3);
        chk("m3_an", bus.an, 8'hF7);
        chk("m3_seg", bus.seg, 7'b1100000);
        show_at(5, 4);
        chk("m4_an", bus.an, 8'hFF);
        show_at(9, 7);
        chk("m7_an", bus.an, 8'hFF);

        goto(4, 2);
        wr(32'h1234_5678, 8'hFF, 8'hFF);
        chk("pre_rst_pend", bus.pending, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_pend", bus.pending, 1'b0);
        chk("mid_rst_an", bus.an, 8'hFF);
        rst = 1'b0;
        goto(0, 0);
        show_at(5, 3);
        chk("dark_an", bus.an, 8'hFF);
        chk("dark_pend", bus.pending, 1'b0);

        wr(32'h0000_0000, 8'hFF, 8'h00);
        goto(0, 0);
        show_at(5, 0);
        chk("z0_an", bus.an, 8'hFE);
        chk("z0_seg", bus.seg, 7'b0000001);
        show_at(5, 1);
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        chk("z1_an", bus.an, 8'hFF);
`else
        chk("z1_an", bus.an, 8'hFD);
`endif
        chk("z1_seg", bus.seg, 7'b0000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexed driver for the 8-digit common-anode seven-segment display on the Nexys A7 board.
- Sits directly downstream of the core's display register. It consumes a 32-bit hex value, a per-digit enable mask and decimal points, and produces the AN and CA..CG/DP pin levels.
- Value updates are double-buffered and applied only at a frame boundary, so a digit never shows a torn value.
- A short blanking window is inserted before each digit switch to suppress ghosting.

Parameters:
- CLK_FREQ_HZ, 50_000_000: frequency of clk.
- REFRESH_HZ, 1000: per-digit slot rate. DIV = CLK_FREQ_HZ/REFRESH_HZ cycles per slot.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must satisfy 1 <= BLANK_CYCLES < DIV.

Ports:
- clk, input, 1: core clock.
- rst, input, 1: synchronous, active-high reset.
- i_wr_en, input, 1: single-cycle write strobe.
- i_wr_data, input, 32: eight hex nibbles; nibble k drives digit k (digit 0 = rightmost).
- i_wr_mask, input, 8: digit enable; 0 = digit always dark.
- i_wr_dp, input, 8: decimal point per digit, 1 = lit.
- o_pending, output, 1: a write is latched but not yet applied.
- o_frame_start, output, 1: one-cycle pulse when digit 0's slot begins.
- o_an, output, 8: anodes, active low.
- o_seg, output, 7: {CA,CB,CC,CD,CE,CF,CG}, active low.
- o_dp_n, output, 1: decimal point, active low.

Behaviour:
- Reset: o_an=8'hFF, o_seg=7'h7F, o_dp_n=1, o_pending=0, o_frame_start=0. Slot counter=0, digit index=0, active and pending registers cleared (data=0, mask=0, dp=0).
- Slot counter counts 0..DIV-1 and wraps. On wrap, the digit index increments modulo 8.
- Per-slot FSM:
  - BLANK while counter < BLANK_CYCLES: o_an=FF, o_seg=7F, o_dp_n=1.
  - SHOW for the remainder of the slot: o_an = ~(1<<idx) if active mask[idx] is set, otherwise FF.
- Frame boundary = counter wrap with idx==7 (next idx=0). o_frame_start pulses for exactly the first cycle of digit 0's slot.
- Outputs are registered. Pin levels lag the counter/index state by 1 cycle and are glitch-free.
- Hex decode, active low, {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- o_dp_n = ~active dp[idx] in SHOW.
- Write handling:
  - i_wr_en latches data/mask/dp into the pending register and sets o_pending on the next cycle.
  - A later write before the boundary overwrites the pending register (last write wins).
  - At the frame boundary, if o_pending is set: active <= pending and o_pending clears.
  - Simultaneous i_wr_en and frame boundary: the write data bypasses into active directly and o_pending stays 0.
  - Writes never alter the currently displayed digit mid-frame.
- Reset asserted mid-slot or mid-frame: all state returns to reset values on the next edge, and any pending write is discarded.
- Arithmetic: counter width = $clog2(DIV), index 3 bits. Wrap is explicit, with no reliance on overflow when DIV is not a power of 2.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- Defined: at apply time, the effective mask clears every enabled digit above the most significant non-zero enabled nibble. Digit 0 is never blanked. Example: data 0x0000_00A5 with mask FF shows only digits 1 and 0.
- Undefined: all enabled digits display, including leading zeros.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, REFRESH_HZ=100 (DIV=10) and BLANK_CYCLES=2.
1. Reset → o_an=FF, o_seg=7F, o_dp_n=1, o_pending=0; 1st o_frame_start pulse 1 cycle after rst deasserts (slot 0 starts at counter=0).
2. Write data=0x8765_4321, mask=FF, dp=0x01 → from the next frame: o_an=FE with o_seg=1001111 and o_dp_n=0 in slot 0; o_an=7F with o_seg=0000000 in slot 7; o_an=FF for the first 2 cycles of every slot.
3. Write 0x1111_1111 mid-frame, then 0x2222_2222 before the boundary → o_pending=1 until the boundary; the current frame still shows the old value; the next frame shows 2 (0010010) on all digits.
4. i_wr_en in the boundary cycle with data 0xFFFF_FFFF → o_pending stays 0; the new frame shows 0111000 on all digits.
5. Mask=0x0F, data=0xDEAD_BEEF → slots 4-7 keep o_an=FF for the whole slot; slots 0-3 show F,E,E,b.
6. rst asserted during a pending write → o_pending=0 and the display stays dark (mask 0) after reset. With SEVENSEG_LEADING_ZERO_BLANK_EN defined, data 0x0000_0000 with mask FF lights only digit 0 with 0000001.
